stream_demux_buffered: RTL and testbench
========================================

Name: stream_demux_buffered

Overview:
- Valid/ready stream demultiplexer: the receiving-side counterpart to the team's mux-based selection blocks.
- One upstream stream carries data plus a per-transfer destination index. Each accepted word is routed into a one-entry holding register for the addressed downstream channel.
- Downstream channels drain independently.
- Sits between a single producer and N_OUT consumers. It also counts words addressed to nonexistent channels.

Parameters:
- WIDTH, 8, data width per word
- N_OUT, 4, number of downstream channels (any value >= 2, not necessarily power of two)
- SEL_W, $clog2(N_OUT), width of destination index
- CNT_W, 8, width of drop counter

Ports:
- clk  input  1  clock
- rst  input  1  reset
- up_valid  input  1  upstream word valid
- up_ready  output  1  upstream word can be accepted this cycle
- up_sel  input  SEL_W  destination channel index, qualified by up_valid
- up_data  input  WIDTH  upstream word
- down_valid  output  N_OUT  bit i: channel i holds a word
- down_ready  input  N_OUT  bit i: channel i consumer accepts
- down_data  output  N_OUT*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
- drop_count  output  CNT_W  saturating count of dropped words

Interface (already decided): one clock; reset is synchronous and active-high (clock port named clk, reset port named rst).

Behaviour:
- Reset (clk edge with rst=1): all slots empty, down_valid=0, down_data=0, drop_count=0. Words held at reset are discarded, not delivered.
- Per-channel state: full[i], data[i]. down_valid[i]=full[i]; down_data slice i = data[i].
- Pop: full[i] && down_ready[i] at a clk edge.
- up_ready, when up_sel < N_OUT: = !full[up_sel] || down_ready[up_sel]. This is combinational from up_sel and down_ready; no combinational path from up_valid.
- up_ready, when up_sel >= N_OUT: = 1. Out-of-range words are always accepted and dropped.
- Push: up_valid && up_ready && up_sel < N_OUT. At the edge, full[up_sel] <= 1 and data[up_sel] <= up_data.
- Latency: accepted word visible on down_valid/down_data the cycle after acceptance. No combinational path from up_data to down_data.
- Simultaneous push and pop, same channel: full stays 1, data replaced by new word. Full throughput of 1 word/cycle per channel when the consumer is always ready.
- Simultaneous push to channel j and pops on other channels: all take effect independently in the same cycle.
- Pop without push: full[i] <= 0; data[i] is held (don't-care when !full).
- Full channel with down_ready=0 blocks only when addressed. up_ready=0 for that sel; other sel values are unaffected (no head-of-line blocking inside the block).
- Drop: up_valid && up_sel >= N_OUT. drop_count increments by 1, saturating at 2^CNT_W-1 (no wrap). No channel state changes. Unreachable when N_OUT is a power of two.
- up_sel and up_data are ignored when up_valid=0.
- Words accepted on the same channel are delivered in acceptance order. Ordering across channels is unconstrained.
- down_valid[i], once asserted, stays asserted with stable data until popped or reset.

Decomposition:
- No shared package required. SEL_W is a derived localparam-style parameter.
- One natural sub-module: stream_slot_reg, a one-entry valid/ready holding register (WIDTH, push, data_in, pop, full, data_out). Instantiated N_OUT times via generate.
- Top level contains only the index decode, the up_ready mux and the drop counter.

Test Plan:
1. Reset, then up_valid=1, sel=2, data=8'hA5 for one cycle, all down_ready=0: up_ready=1 -> next cycle down_valid=4'b0100, slice 2 = 8'hA5. Drive rst=1 one cycle -> down_valid=0, down_data=0.
2. Channel 1 full, down_ready[1]=0, offer sel=1, data=8'h11 -> up_ready=0 and nothing changes. Same cycle switch sel=3, data=8'h33 -> up_ready=1; next cycle down_valid=4'b1010.
3. sel=0, down_ready[0]=1 held, 5 back-to-back words 1..5 -> up_ready=1 every cycle; channel 0 presents 1,2,3,4,5 on consecutive cycles, no gaps, no loss.
4. Random sel/data/down_ready, 10k cycles, N_OUT=4 -> scoreboard per-channel FIFO order exact, no duplicates. Held data stable while down_valid && !down_ready.
5. N_OUT=3, CNT_W=2: send sel=3 six times -> up_ready=1 each time, no down_valid change; drop_count goes 1,2,3,3,3,3.
6. Push to channel 2 while channel 2 pops and channel 0 pops in the same cycle -> channel 2 shows new data with down_valid[2]=1; down_valid[0]=0.

Source files
------------

// File: rtl/stream_demux_buffered_pkg.sv
// Shared defaults and helpers for the buffered stream demultiplexer.
package stream_demux_buffered_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefNOut  = 4;
  localparam int unsigned DefCntW  = 8;

  // Index width for n channels; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_slot_reg.sv
// One-entry valid/ready holding register; a push wins over a pop in the same cycle.
module stream_slot_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_push) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_pop) begin
      // Data is left in place; it is meaningless once the slot is empty.
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/stream_demux_buffered.sv
// Valid/ready demultiplexer: routes each upstream word into a per-channel holding slot
// and counts words addressed to channels that do not exist.
module stream_demux_buffered
  import stream_demux_buffered_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned N_OUT = DefNOut,
  parameter int unsigned SEL_W = sel_width(N_OUT),
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   up_valid,
  output logic                   up_ready,
  input  logic [SEL_W-1:0]       up_sel,
  input  logic [WIDTH-1:0]       up_data,
  output logic [N_OUT-1:0]       down_valid,
  input  logic [N_OUT-1:0]       down_ready,
  output logic [N_OUT*WIDTH-1:0] down_data,
  output logic [CNT_W-1:0]       drop_count
);

  logic [N_OUT-1:0] w_full;
  logic [N_OUT-1:0] w_slot_ready;
  logic [N_OUT-1:0] w_push;
  logic [N_OUT-1:0] w_pop;
  logic [WIDTH-1:0] w_slot_data [N_OUT];
  logic             w_in_range;
  logic             w_ready_sel;
  logic             w_drop;
  logic [CNT_W-1:0] r_drop_count;

  assign w_slot_ready = ~w_full | down_ready;
  assign w_pop        = w_full & down_ready;

  // Out-of-range indices fall through with ready=1 so they are accepted and dropped.
  always_comb begin
    w_in_range  = 1'b0;
    w_ready_sel = 1'b1;
    w_push      = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      if (up_sel == SEL_W'(i)) begin
        w_in_range  = 1'b1;
        w_ready_sel = w_slot_ready[i];
        w_push[i]   = up_valid && w_slot_ready[i];
      end
    end
  end

  assign up_ready = w_ready_sel;
  assign w_drop   = up_valid && !w_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != {CNT_W{1'b1}})) begin
      r_drop_count <= r_drop_count + CNT_W'(1);
    end
  end

  assign drop_count = r_drop_count;

  for (genvar g = 0; g < int'(N_OUT); g++) begin : g_slot
    stream_slot_reg #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .i_push (w_push[g]),
      .i_data (up_data),
      .i_pop  (w_pop[g]),
      .o_full (w_full[g]),
      .o_data (w_slot_data[g])
    );

    assign down_data[g*WIDTH +: WIDTH] = w_slot_data[g];
  end

  assign down_valid = w_full;

endmodule

// File: tb/tb_stream_demux_buffered.sv
// Scoreboard bench: the driver queues each accepted word per channel, the monitor
// pops and compares on every downstream handshake.
module tb_stream_demux_buffered;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_valid;
  logic        up_ready;
  logic [1:0]  up_sel;
  logic [7:0]  up_data;
  logic [3:0]  down_valid;
  logic [3:0]  down_ready;
  logic [31:0] down_data;
  logic [7:0]  drop_count;

  logic        up3_valid;
  logic        up3_ready;
  logic [1:0]  up3_sel;
  logic [7:0]  up3_data;
  logic [2:0]  down3_valid;
  logic [2:0]  down3_ready;
  logic [23:0] down3_data;
  logic [1:0]  drop3_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q [4][$];
  logic       prev_v [4];
  logic       prev_r [4];
  logic [7:0] prev_d [4];

  always #5 clk = ~clk;

  stream_demux_buffered #(
    .WIDTH (8),
    .N_OUT (4),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_sel     (up_sel),
    .up_data    (up_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .drop_count (drop_count)
  );

  stream_demux_buffered #(
    .WIDTH (8),
    .N_OUT (3),
    .CNT_W (2)
  ) dut3 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up3_valid),
    .up_ready   (up3_ready),
    .up_sel     (up3_sel),
    .up_data    (up3_data),
    .down_valid (down3_valid),
    .down_ready (down3_ready),
    .down_data  (down3_data),
    .drop_count (drop3_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Capacity-one FIFO per channel: ready when empty or when the consumer drains now.
  task automatic cycle(input logic v, input logic [1:0] sel, input logic [7:0] d,
                       input logic [3:0] dr);
    logic exp_rdy;
    @(posedge clk); #1;
    up_valid   = v;
    up_sel     = sel;
    up_data    = d;
    down_ready = dr;
    exp_rdy    = (exp_q[sel].size() == 0) || dr[sel];
    if (v && exp_rdy) exp_q[sel].push_back(d);
    @(negedge clk);
    chk("up_ready", {31'd0, up_ready}, {31'd0, exp_rdy});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst        = 1'b1;
    up_valid   = 1'b0;
    down_ready = '0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) prev_v[i] <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [7:0] d;
        d = down_data[i*8 +: 8];
        if (prev_v[i] && !prev_r[i]) begin
          chk($sformatf("hold_valid%0d", i), {31'd0, down_valid[i]}, 32'd1);
          chk($sformatf("hold_data%0d", i), {24'd0, d}, {24'd0, prev_d[i]});
        end
        if (down_valid[i] && down_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("spurious%0d", i), {24'd0, d}, 32'hFFFF_FFFF);
          end else begin
            chk($sformatf("data%0d", i), {24'd0, d}, {24'd0, exp_q[i].pop_front()});
          end
        end
        prev_v[i] <= down_valid[i];
        prev_r[i] <= down_ready[i];
        prev_d[i] <= d;
      end
    end
  end

  initial begin
    int exp_drop;
    rst         = 1'b1;
    up_valid    = 1'b0;
    up_sel      = '0;
    up_data     = '0;
    down_ready  = '0;
    up3_valid   = 1'b0;
    up3_sel     = '0;
    up3_data    = '0;
    down3_ready = '0;
    do_reset();
    @(negedge clk);
    chk("rst_valid", {28'd0, down_valid}, 32'd0);
    chk("rst_data", down_data, 32'd0);
    chk("rst_drop", {24'd0, drop_count}, 32'd0);

    // Single word to channel 2, then reset discards it.
    cycle(1'b1, 2'd2, 8'hA5, 4'b0000);
    cycle(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("t1_valid", {28'd0, down_valid}, 32'h4);
    chk("t1_data", {24'd0, down_data[16 +: 8]}, 32'hA5);
    do_reset();
    @(negedge clk);
    chk("t1_rst_valid", {28'd0, down_valid}, 32'd0);
    chk("t1_rst_data", down_data, 32'd0);

    // Blocked channel 1 does not block channel 3.
    cycle(1'b1, 2'd1, 8'h10, 4'b0000);
    cycle(1'b1, 2'd1, 8'h11, 4'b0000);
    cycle(1'b1, 2'd3, 8'h33, 4'b0000);
    cycle(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("t2_valid", {28'd0, down_valid}, 32'hA);
    chk("t2_data1", {24'd0, down_data[8 +: 8]}, 32'h10);
    cycle(1'b0, 2'd0, 8'h00, 4'b1111);

    // Back-to-back stream on channel 0.
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b1, 2'd0, 8'(k), 4'b0001);
      if (k > 1) begin
        chk("t3_valid", {31'd0, down_valid[0]}, 32'd1);
        chk("t3_data", {24'd0, down_data[7:0]}, k - 1);
      end
    end
    cycle(1'b0, 2'd0, 8'h00, 4'b0001);
    chk("t3_last", {24'd0, down_data[7:0]}, 32'd5);
    cycle(1'b0, 2'd0, 8'h00, 4'b1111);

    // Push to channel 2 while channels 2 and 0 both pop.
    cycle(1'b1, 2'd2, 8'h21, 4'b0000);
    cycle(1'b1, 2'd0, 8'h01, 4'b0000);
    cycle(1'b1, 2'd2, 8'h22, 4'b0101);
    cycle(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("t6_valid0", {31'd0, down_valid[0]}, 32'd0);
    chk("t6_valid2", {31'd0, down_valid[2]}, 32'd1);
    chk("t6_data2", {24'd0, down_data[16 +: 8]}, 32'h22);
    cycle(1'b0, 2'd0, 8'h00, 4'b1111);

    // Randomized traffic.
    for (int n = 0; n < 10000; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 4'($urandom));
    end
    for (int n = 0; n < 4; n++) cycle(1'b0, 2'd0, 8'h00, 4'b1111);
    for (int i = 0; i < 4; i++) chk($sformatf("drain%0d", i), exp_q[i].size(), 32'd0);
    chk("drop4", {24'd0, drop_count}, 32'd0);

    // Out-of-range index on the three-channel instance saturates a 2-bit counter.
    exp_drop = 0;
    @(posedge clk); #1;
    up3_valid = 1'b1;
    up3_sel   = 2'd3;
    up3_data  = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_ready", {31'd0, up3_ready}, 32'd1);
      @(posedge clk); #1;
      exp_drop = (exp_drop == 3) ? 3 : exp_drop + 1;
      chk("t5_drop", {30'd0, drop3_count}, exp_drop);
      chk("t5_valid", {29'd0, down3_valid}, 32'd0);
      up3_data = 8'($urandom);
      if (k == 5) up3_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
